// File: rtl/id_fwd_pkg.sv
// -----------------------------------------------------------------------------
// id_fwd_pkg
//   Shared types and constants for the ID-stage forwarding / hazard unit.
//   - sb_entry_t : one scoreboard entry (valid, destination, load flag)
//   - OP_BR      : ID op class that reads rs1 and rs2
//   - OP_JALR    : ID op class that reads rs1 only
//   - SEL_W      : forward-select width for the default depth
// -----------------------------------------------------------------------------
package id_fwd_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DEPTH_DEF  = 3;
    localparam int SEL_W      = $clog2(DEPTH_DEF + 1);

    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    // Entry layout is fixed here, so the top's REG_AW must equal REG_AW_DEF.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/id_fwd_match.sv
// -----------------------------------------------------------------------------
// id_fwd_match
//   Combinational priority search for one ID operand over the scoreboard.
//   Ports:
//     i_use   : operand is actually read by the ID instruction
//     i_rs    : operand register address
//     i_sb    : scoreboard, index 0 = youngest (EX)
//     o_sel   : 0 = register file, k = stage k-1
//     o_stall : youngest producer exists but its result is not yet forwardable
// -----------------------------------------------------------------------------
module id_fwd_match
    import id_fwd_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 5,
    parameter int ALU_READY  = 0,
    parameter int LOAD_READY = 1,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                  i_use,
    input  logic [REG_AW-1:0]     i_rs,
    input  sb_entry_t [DEPTH-1:0] i_sb,
    output logic [SW-1:0]         o_sel,
    output logic                  o_stall
);

    // NOTE: every output gets a default before any conditional assignment,
    // otherwise the combinational block infers a latch.
    always_comb begin
        o_sel   = '0;
        o_stall = 1'b0;
        // Walk from oldest to youngest so the youngest match is written last
        // and wins. rs = 0 never hits because rd = 0 entries are never valid.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_use && i_sb[k].valid && (i_sb[k].rd == i_rs)) begin
                if (k >= (i_sb[k].is_load ? LOAD_READY : ALU_READY)) begin
                    o_sel   = SW'(k + 1);
                    o_stall = 1'b0;
                end else begin
                    o_sel   = '0;
                    o_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// id_fwd_scoreboard
//   ID-stage operand forwarding and hazard unit for branch / jalr resolution.
//   Tracks one in-flight write per downstream stage and, per ID operand,
//   selects the youngest ready producer or requests a stall.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     i_id_*            : ID instruction (valid, op, rs1, rs2, rd, wen, is_load)
//     i_ext_stall       : downstream stall, freezes scoreboard and counter
//     i_flush           : squash the ID instruction
//     o_fwd_sel1/2      : operand source, 0 = regfile, k = stage k-1
//     o_hz_stall        : hold IF/ID and insert a bubble
//     o_stall_cnt       : saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module id_fwd_scoreboard
    import id_fwd_pkg::*;
#(
    parameter int         REG_AW     = REG_AW_DEF,
    parameter int         DEPTH      = DEPTH_DEF,
    parameter int         ALU_READY  = 0,
    parameter int         LOAD_READY = 1,
    parameter logic [2:0] BR_OP      = OP_BR,
    parameter logic [2:0] JALR_OP    = OP_JALR,
    parameter int         CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_id_valid,
    input  logic [2:0]                   i_id_op,
    input  logic [REG_AW-1:0]            i_id_rs1,
    input  logic [REG_AW-1:0]            i_id_rs2,
    input  logic [REG_AW-1:0]            i_id_rd,
    input  logic                         i_id_wen,
    input  logic                         i_id_is_load,
    input  logic                         i_ext_stall,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   o_fwd_sel2,
    output logic                         o_hz_stall,
    output logic [CNT_W-1:0]             o_stall_cnt
);

    localparam int SW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] r_sb;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_live, w_use1, w_use2, w_stall1, w_stall2, w_hz_stall, w_enter;
    logic [SW-1:0] w_sel1, w_sel2;

    // A squashed or empty ID slot reads nothing.
    assign w_live = i_id_valid && !i_flush;
    assign w_use1 = w_live && ((i_id_op == BR_OP) || (i_id_op == JALR_OP));
    assign w_use2 = w_live && (i_id_op == BR_OP);

    id_fwd_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SW(SW)
    ) u_match1 (
        .i_use(w_use1), .i_rs(i_id_rs1), .i_sb(r_sb),
        .o_sel(w_sel1), .o_stall(w_stall1)
    );

    id_fwd_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SW(SW)
    ) u_match2 (
        .i_use(w_use2), .i_rs(i_id_rs2), .i_sb(r_sb),
        .o_sel(w_sel2), .o_stall(w_stall2)
    );

    assign w_hz_stall = w_stall1 || w_stall2;
    assign w_enter    = i_id_valid && !i_flush && !w_hz_stall;

    // NOTE: the scoreboard is a handful of flops, not a RAM, so every entry is
    // reset; a stale valid bit after reset would forward garbage.
    // NOTE: non-blocking assignments make every stage read its neighbour's
    // pre-edge value, which is what a shift register needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb        <= '0;
            r_stall_cnt <= '0;
        end else if (!i_ext_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_enter) begin
                r_sb[0].valid   <= i_id_wen && (i_id_rd != '0);
                r_sb[0].rd      <= i_id_rd;
                r_sb[0].is_load <= i_id_is_load;
            end else begin
                r_sb[0] <= '0;
            end
            if (w_hz_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_fwd_sel1  = w_sel1;
    assign o_fwd_sel2  = w_sel2;
    assign o_hz_stall  = w_hz_stall;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_id_fwd_scoreboard
//   Directed bench for id_fwd_scoreboard with a list-of-producers model.
//   The counter is built narrow so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_id_fwd_scoreboard;

    localparam int         DEPTH  = 3;
    localparam int         CNT_W  = 3;
    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_BRC = 3'b110;
    localparam logic [2:0] OP_JR  = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_wen, id_is_load, ext_stall, flush;
    logic [2:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic       hz_stall;
    logic [CNT_W-1:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_fwd_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(id_valid), .i_id_op(id_op),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_id_wen(id_wen), .i_id_is_load(id_is_load),
        .i_ext_stall(ext_stall), .i_flush(flush),
        .o_fwd_sel1(fwd_sel1), .o_fwd_sel2(fwd_sel2),
        .o_hz_stall(hz_stall), .o_stall_cnt(stall_cnt)
    );

    // ---------------- model: producers by age, 0 = issued last cycle --------
    logic       m_v  [DEPTH];
    logic [4:0] m_rd [DEPTH];
    logic       m_ld [DEPTH];
    int         m_cnt;

    // Result of one operand read: where it comes from, or that it must wait.
    function automatic int want_sel(input logic used, input logic [4:0] rs,
                                    output logic must_wait);
        must_wait = 1'b0;
        if (!used || rs == 5'd0) return 0;
        for (int age = 0; age < DEPTH; age++) begin
            if (m_v[age] && m_rd[age] == rs) begin
                // Loads are usable from MEM (age 1), ALU results from EX.
                if (age >= (m_ld[age] ? 1 : 0)) return age + 1;
                must_wait = 1'b1;
                return 0;
            end
        end
        return 0;
    endfunction

    function automatic void want_all(output int s1, output int s2,
                                     output logic hz);
        logic live, w1, w2;
        live = id_valid && !flush;
        s1 = want_sel(live && (id_op == OP_BRC || id_op == OP_JR), id_rs1, w1);
        s2 = want_sel(live && (id_op == OP_BRC), id_rs2, w2);
        hz = w1 || w2;
    endfunction

    always @(posedge clk or posedge rst) begin
        int   s1, s2;
        logic hz;
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_v[a]  <= 1'b0;
                m_rd[a] <= '0;
                m_ld[a] <= 1'b0;
            end
            m_cnt <= 0;
        end else if (!ext_stall) begin
            want_all(s1, s2, hz);
            for (int a = 1; a < DEPTH; a++) begin
                m_v[a]  <= m_v[a-1];
                m_rd[a] <= m_rd[a-1];
                m_ld[a] <= m_ld[a-1];
            end
            if (hz || flush || !id_valid) begin
                m_v[0]  <= 1'b0;
                m_rd[0] <= '0;
                m_ld[0] <= 1'b0;
            end else begin
                m_v[0]  <= id_wen && id_rd != 5'd0;
                m_rd[0] <= id_rd;
                m_ld[0] <= id_is_load;
            end
            if (hz && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_compare();
        int   s1, s2;
        logic hz;
        if (rst) return;
        want_all(s1, s2, hz);
        check("sel1_vs_model", int'(fwd_sel1), s1);
        check("sel2_vs_model", int'(fwd_sel2), s2);
        check("hz_vs_model", int'(hz_stall), int'(hz));
        check("cnt_vs_model", int'(stall_cnt), m_cnt);
    endtask

    // One cycle: compare the current cycle at negedge, then drive the next.
    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic xs, input logic fl);
        @(negedge clk);
        model_compare();
        @(posedge clk);
        #1;
        id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_wen = wen; id_is_load = ld; ext_stall = xs; flush = fl;
        #1;
    endtask

    task automatic nop();                      drive(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic add(input logic [4:0] rd);  drive(1, OP_ALU, 0, 0, rd, 1, 0, 0, 0); endtask
    task automatic lw(input logic [4:0] rd);   drive(1, OP_LD, 0, 0, rd, 1, 1, 0, 0); endtask
    task automatic br(input logic [4:0] a, input logic [4:0] b, input logic xs = 0,
                      input logic fl = 0);
        drive(1, OP_BRC, a, b, 0, 0, 0, xs, fl);
    endtask
    task automatic jalr(input logic [4:0] a, input logic [4:0] b);
        drive(1, OP_JR, a, b, 0, 0, 0, 0, 0);
    endtask

    initial begin
        id_valid = 1; id_op = OP_BRC; id_rs1 = 1; id_rs2 = 2; id_rd = 0;
        id_wen = 0; id_is_load = 0; ext_stall = 0; flush = 0;
        #2;
        check("reset_sel1", int'(fwd_sel1), 0);
        check("reset_sel2", int'(fwd_sel2), 0);
        check("reset_hz", int'(hz_stall), 0);
        check("reset_cnt", int'(stall_cnt), 0);
        nop();
        rst = 0;

        // ALU producer: EX then MEM
        add(5);
        br(5, 0);  check("alu_ex_sel1", int'(fwd_sel1), 1); check("alu_ex_hz", int'(hz_stall), 0);
        br(5, 0);  check("alu_mem_sel1", int'(fwd_sel1), 2);

        // Load-use: exactly one stall, then MEM forward
        lw(7);
        br(0, 7);  check("ld_use_hz", int'(hz_stall), 1); check("ld_use_sel2", int'(fwd_sel2), 0);
                   check("ld_use_cnt0", int'(stall_cnt), 0);
        br(0, 7);  check("ld_fwd_sel2", int'(fwd_sel2), 2); check("ld_fwd_hz", int'(hz_stall), 0);
                   check("ld_cnt1", int'(stall_cnt), 1);

        // Youngest producer wins
        add(3); add(3);
        br(3, 0);  check("prio_sel1", int'(fwd_sel1), 1);

        // rd = x0 never tracked; JALR ignores rs2
        add(0);
        jalr(0, 0); check("x0_sel1", int'(fwd_sel1), 0); check("x0_hz", int'(hz_stall), 0);
        add(4);
        jalr(0, 4); check("jalr_sel2", int'(fwd_sel2), 0); check("jalr_hz", int'(hz_stall), 0);

        // ext_stall freezes the load in EX and the counter
        lw(9);
        for (int i = 0; i < 3; i++) begin
            br(9, 0, 1);
            check("xs_hz", int'(hz_stall), 1);
            check("xs_cnt", int'(stall_cnt), 1);
        end
        br(9, 0);  check("xs_rel_hz", int'(hz_stall), 1);
        br(9, 0);  check("xs_rel_sel1", int'(fwd_sel1), 2); check("xs_rel_cnt", int'(stall_cnt), 2);

        // flush: instruction becomes a bubble; flushed branch reads nothing
        drive(1, OP_ALU, 0, 0, 6, 1, 0, 0, 1);
        br(6, 0);  check("flush_bubble_sel1", int'(fwd_sel1), 0);
        lw(8);
        br(8, 0, 0, 1); check("flush_no_hz", int'(hz_stall), 0);

        // Both operands
        add(11); add(12);
        br(11, 12); check("diff_sel1", int'(fwd_sel1), 2); check("diff_sel2", int'(fwd_sel2), 1);
        br(12, 12); check("same_sel1", int'(fwd_sel1), 2); check("same_sel2", int'(fwd_sel2), 2);

        // Counter saturates at all-ones (2 + 6 stalls, 3-bit counter)
        for (int i = 0; i < 6; i++) begin
            lw(13); br(13, 0); br(13, 0);
        end
        nop();     check("cnt_saturated", int'(stall_cnt), 7);

        // Asynchronous reset mid-operation
        lw(10);
        br(10, 0); check("pre_rst_hz", int'(hz_stall), 1);
        rst = 1;
        #1;
        check("async_rst_hz", int'(hz_stall), 0);
        check("async_rst_cnt", int'(stall_cnt), 0);
        nop();
        rst = 0;
        br(10, 0); check("post_rst_sel1", int'(fwd_sel1), 0); check("post_rst_hz", int'(hz_stall), 0);
        nop();

        @(negedge clk);
        model_compare();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Parametrised next-generation ID-stage operand forwarding and hazard unit for branch and jalr resolution in ID.
- Keeps a registered scoreboard of in-flight writes, one entry per downstream stage (EX, MEM, WB, ...).
- Per ID operand, selects the youngest ready producer, or requests a stall when that producer's result is not yet available (load-use, or ALU-in-EX when ALU_READY > 0).
- Sits beside the ID decoder; drives the ID compare-operand muxes and the IF/ID hold logic.

Parameters:
- REG_AW, 5: register address width.
- DEPTH, 3: number of tracked downstream stages. Index 0 = EX, 1 = MEM, 2 = WB.
- ALU_READY, 0: lowest stage index at which an ALU result is forwardable.
- LOAD_READY, 1: lowest stage index at which load data is forwardable. Must satisfy LOAD_READY >= ALU_READY and LOAD_READY < DEPTH.
- BR_OP, 3'b110: op code using rs1 and rs2.
- JALR_OP, 3'b111: op code using rs1 only.
- CNT_W, 16: stall-counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- id_valid, in, 1: ID holds a valid instruction.
- id_op, in, 3: ID op class.
- id_rs1, in, REG_AW: ID source 1.
- id_rs2, in, REG_AW: ID source 2.
- id_rd, in, REG_AW: ID destination.
- id_wen, in, 1: ID instruction writes rd.
- id_is_load, in, 1: ID instruction is a load.
- ext_stall, in, 1: downstream stall; freezes the scoreboard.
- flush, in, 1: squash the ID instruction (do not enter it).
- fwd_sel1, out, $clog2(DEPTH+1): rs1 source. 0 = register file; k = stage k-1.
- fwd_sel2, out, $clog2(DEPTH+1): rs2 source, same encoding.
- hz_stall, out, 1: hold IF/ID and insert a bubble.
- stall_cnt, out, CNT_W: saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard entry per stage: valid, rd, is_load.
- Reset (async, rst=1): all entries invalid, stall_cnt = 0. With no valid entries, outputs read fwd_sel1 = fwd_sel2 = 0 and hz_stall = 0.
- Reset mid-operation clears all entries immediately; no partial state survives.
- Shift on each clk edge only when ext_stall = 0:
  - stage[k] <= stage[k-1] for k >= 1.
  - stage[0] <= bubble (valid = 0) if hz_stall, flush, or !id_valid.
  - Otherwise stage[0] <= {id_wen && id_rd != 0, id_rd, id_is_load}.
- ext_stall = 1: all entries and stall_cnt hold. flush during ext_stall has no effect; the flush source keeps it asserted until ext_stall drops.
- Operand use, decided combinationally:
  - op == BR_OP: uses rs1 and rs2.
  - op == JALR_OP: uses rs1 only.
  - any other op: no operand used; fwd_sel = 0 and no stall.
  - id_valid = 0 or flush = 1: no operand used.
- Per used operand rs:
  - Find the lowest k with stage[k].valid && stage[k].rd == rs (youngest producer wins; older matches are ignored).
  - rs == 0 never matches, because rd = 0 entries are always invalid.
  - Ready when k >= (stage[k].is_load ? LOAD_READY : ALU_READY).
  - No match: sel = 0.
  - Match and ready: sel = k+1.
  - Match and not ready: sel = 0, operand stalls.
- hz_stall = OR of the operand stalls. It is combinational from registered state plus ID inputs, so latency is 0 cycles.
- A stall resolves automatically as the producer advances: a load in EX with LOAD_READY = 1 gives exactly one stall cycle, then sel = 2.
- stall_cnt increments when hz_stall && !ext_stall and saturates at all-ones.
- Both operands matching different stages select independently.
- Both operands matching the same entry select the same value.

Decomposition:
- Shared package id_fwd_pkg holds:
  - typedef sb_entry_t {valid, rd, is_load};
  - op constants OP_BR, OP_JALR;
  - localparam SEL_W = $clog2(DEPTH+1).
- One sub-module, id_fwd_match: combinational per-operand priority search over DEPTH entries, returning sel and stall. It is instantiated twice.

Test Plan:
- Reset then idle: rst pulse with BR x1,x2 in ID -> sel1 = sel2 = 0, hz_stall = 0, stall_cnt = 0.
- ALU producer: ADD x5 (wen) enters, next cycle BR rs1=x5 -> sel1 = 1 (EX), no stall. One cycle later -> sel1 = 2 (MEM).
- Load-use: LW x7 enters, next cycle BR rs2=x7 -> hz_stall = 1 for exactly 1 cycle, then sel2 = 2, stall_cnt = 1, one bubble in stage 0.
- Priority: ADD x3 then ADD x3 enter back-to-back, then BR rs1=x3 -> sel1 = 1 (the younger producer), not 2.
- rd = x0 and JALR: ADD x0 enters, then JALR rs1=x0 rs2=x0 -> sel = 0, no stall. JALR rs2 matching a producer -> sel2 = 0.
- ext_stall and flush: LW x9 enters, then ext_stall = 1 for 3 cycles with BR rs1=x9 -> entries frozen, hz_stall held at 1, stall_cnt unchanged. After release, one stall cycle then sel1 = 2. flush = 1 -> stage 0 receives a bubble.
